// File: rtl/timer_pkg.sv
// Shared definitions for the clock's timer blocks: mode codes, BCD limits,
// the timer state encoding and a BCD digit validity helper.
package timer_pkg;

    localparam logic [1:0]  MODE_CLOCK  = 2'd0;
    localparam logic [1:0]  MODE_UTIMER = 2'd1;
    localparam logic [1:0]  MODE_DTIMER = 2'd2;

    localparam logic [15:0] BCD_ZERO = 16'h0000;
    localparam logic [15:0] BCD_MAX  = 16'h9959;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    // True when every digit of an MM:SS value is in range (units 0-9, sec tens 0-5).
    function automatic logic bcd_mmss_valid(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
               (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9);
    endfunction

endpackage

// File: rtl/up_timer_tracker_if.sv
// Control/status bundle between the up timer and its user (buttons, mode,
// target in; count and flags out).
interface up_timer_tracker_if;

    logic [1:0]  buttons_in;
    logic [1:0]  mode;
    logic [15:0] target_bcd;
    logic [15:0] utimer_bcd;
    logic        running;
    logic        alarm;

    modport master (
        output buttons_in, mode, target_bcd,
        input  utimer_bcd, running, alarm
    );

    modport slave (
        input  buttons_in, mode, target_bcd,
        output utimer_bcd, running, alarm
    );

endinterface

// File: rtl/up_timer_tracker_bcd_mmss_inc.sv
// Combinational MM:SS BCD incrementer. Saturates at 99:59: sat is raised and
// the value is passed through unchanged.
module bcd_mmss_inc
    import timer_pkg::*;
(
    input  logic [15:0] bcd_in,
    output logic [15:0] bcd_out,
    output logic        sat
);

    // Ripple carry through sec units, sec tens, min units, min tens.
    always_comb begin
        bcd_out = bcd_in;
        sat     = (bcd_in == BCD_MAX);
        if (!sat) begin
            if (bcd_in[3:0] != 4'd9) begin
                bcd_out[3:0] = bcd_in[3:0] + 4'd1;
            end else begin
                bcd_out[3:0] = 4'd0;
                if (bcd_in[7:4] != 4'd5) begin
                    bcd_out[7:4] = bcd_in[7:4] + 4'd1;
                end else begin
                    bcd_out[7:4] = 4'd0;
                    if (bcd_in[11:8] != 4'd9) begin
                        bcd_out[11:8] = bcd_in[11:8] + 4'd1;
                    end else begin
                        bcd_out[11:8]  = 4'd0;
                        bcd_out[15:12] = bcd_in[15:12] + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/up_timer_tracker.sv
// Count-up MM:SS stopwatch in packed BCD. Start/stop and clear come from the
// push buttons (honoured only in this block's mode); counting itself keeps
// going in the background whatever mode the display is in.
module up_timer_tracker
    import timer_pkg::*;
#(
    parameter logic [1:0] MODE_ID  = MODE_UTIMER,
    parameter int         TICK_DIV = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    up_timer_tracker_if.slave  bus
);

    localparam int             PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

    logic [1:0]    btn_p0, btn_p1, btn_p2;
    logic          ctrl_en, press_start, press_clr;
    timer_state_t  state;
    logic [PW-1:0] presc;
    logic [15:0]   count, count_inc;
    logic          count_sat, tick, target_hit;
    logic          alarm_q;

    // Two-flop synchroniser plus previous-value register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= 2'b00;
            btn_p1 <= 2'b00;
            btn_p2 <= 2'b00;
        end else begin
            btn_p0 <= bus.buttons_in;
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
        end
    end

    assign ctrl_en     = (bus.mode == MODE_ID);
    assign press_start = ctrl_en & btn_p1[0] & ~btn_p2[0];
    assign press_clr   = ctrl_en & btn_p1[1] & ~btn_p2[1];

    assign tick = (state == RUN) && (presc == PMAX);

    bcd_mmss_inc u_inc (
        .bcd_in  (count),
        .bcd_out (count_inc),
        .sat     (count_sat)
    );

    // Target 00:00 disables matching; malformed targets can never match.
    assign target_hit = (bus.target_bcd != BCD_ZERO) &&
                        bcd_mmss_valid(bus.target_bcd) &&
                        (count_inc == bus.target_bcd);

    // Timer FSM with prescaler, count and latched alarm; clear beats start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= '0;
            count   <= BCD_ZERO;
            alarm_q <= 1'b0;
        end else if (press_clr) begin
            state   <= IDLE;
            presc   <= '0;
            count   <= BCD_ZERO;
            alarm_q <= 1'b0;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (press_start) begin
                        state <= RUN;
                        presc <= '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc <= '0;
                        if (count_sat) begin
                            alarm_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            count <= count_inc;
                            if (target_hit) begin
                                alarm_q <= 1'b1;
                                state   <= DONE;
                            end else if (press_start) begin
                                state <= PAUSE;
                            end
                        end
                    end else begin
                        presc <= presc + PW'(1);
                        if (press_start) begin
                            state <= PAUSE;
                        end
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

    assign bus.utimer_bcd = count;
    assign bus.running    = (state == RUN);
    assign bus.alarm      = alarm_q;

endmodule

// File: tb/tb_up_timer_tracker.sv
// Directed bench for up_timer_tracker with TICK_DIV=4. All stimulus is driven
// and all outputs sampled on the falling clock edge.
module tb_up_timer_tracker;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    up_timer_tracker_if bus ();

    up_timer_tracker #(
        .MODE_ID  (2'd1),
        .TICK_DIV (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raw button high for exactly one clock, starting at the current falling edge.
    task automatic press(input int idx);
        bus.buttons_in[idx] = 1'b1;
        @(negedge clk);
        bus.buttons_in[idx] = 1'b0;
    endtask

    task automatic wait_count(input logic [15:0] val, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.utimer_bcd !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.utimer_bcd, val);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.buttons_in = 2'b00;
        bus.mode       = 2'd1;
        bus.target_bcd = 16'h0000;
        cyc(3);
        rst = 1'b0;
        check("reset_count", bus.utimer_bcd, 16'h0000);
        check("reset_running", {15'd0, bus.running}, 16'd0);
        check("reset_alarm", {15'd0, bus.alarm}, 16'd0);

        // 1: start, first step 4 clocks after entering RUN
        press(0);
        cyc(1);
        check("t1_not_yet_running", {15'd0, bus.running}, 16'd0);
        cyc(1);
        check("t1_running", {15'd0, bus.running}, 16'd1);
        cyc(3);
        check("t1_before_first_step", bus.utimer_bcd, 16'h0000);
        cyc(1);
        check("t1_step1", bus.utimer_bcd, 16'h0001);
        cyc(4);
        check("t1_step2", bus.utimer_bcd, 16'h0002);
        cyc(4);
        check("t1_step3", bus.utimer_bcd, 16'h0003);
        cyc(4);
        check("t1_step4", bus.utimer_bcd, 16'h0004);
        check("t1_still_running", {15'd0, bus.running}, 16'd1);

        // 2: carries sec->min and min units->min tens
        wait_count(16'h0059, 400, "t2_reach_0059");
        cyc(3);
        check("t2_hold_0059", bus.utimer_bcd, 16'h0059);
        cyc(1);
        check("t2_carry_0100", bus.utimer_bcd, 16'h0100);
        wait_count(16'h0959, 3000, "t2_reach_0959");
        cyc(4);
        check("t2_carry_1000", bus.utimer_bcd, 16'h1000);
        press(1);
        cyc(2);
        check("t2_clear_count", bus.utimer_bcd, 16'h0000);
        check("t2_clear_running", {15'd0, bus.running}, 16'd0);

        // 3: target match latches alarm and stops
        bus.target_bcd = 16'h0005;
        press(0);
        wait_count(16'h0005, 100, "t3_reach_target");
        check("t3_alarm", {15'd0, bus.alarm}, 16'd1);
        check("t3_stopped", {15'd0, bus.running}, 16'd0);
        cyc(10);
        check("t3_hold", bus.utimer_bcd, 16'h0005);
        press(0);
        cyc(6);
        check("t3_start_ignored_run", {15'd0, bus.running}, 16'd0);
        check("t3_start_ignored_cnt", bus.utimer_bcd, 16'h0005);
        press(1);
        cyc(2);
        check("t3_clear_count", bus.utimer_bcd, 16'h0000);
        check("t3_clear_alarm", {15'd0, bus.alarm}, 16'd0);
        bus.target_bcd = 16'h0000;

        // 4: overflow at 99:59 holds and alarms
        press(0);
        wait_count(16'h9959, 30000, "t4_reach_9959");
        check("t4_running_at_max", {15'd0, bus.running}, 16'd1);
        cyc(3);
        check("t4_no_alarm_yet", {15'd0, bus.alarm}, 16'd0);
        cyc(1);
        check("t4_hold_9959", bus.utimer_bcd, 16'h9959);
        check("t4_alarm", {15'd0, bus.alarm}, 16'd1);
        check("t4_done", {15'd0, bus.running}, 16'd0);
        cyc(8);
        check("t4_no_wrap", bus.utimer_bcd, 16'h9959);
        press(1);
        cyc(2);
        check("t4_clear_count", bus.utimer_bcd, 16'h0000);

        // 5: pause, mode gating, resume
        press(0);
        wait_count(16'h0002, 50, "t5_reach_0002");
        press(0);
        cyc(20);
        check("t5_frozen", bus.utimer_bcd, 16'h0002);
        check("t5_paused", {15'd0, bus.running}, 16'd0);
        bus.mode = 2'd2;
        press(0);
        cyc(10);
        check("t5_mode2_paused", {15'd0, bus.running}, 16'd0);
        check("t5_mode2_frozen", bus.utimer_bcd, 16'h0002);
        bus.mode = 2'd1;
        press(0);
        cyc(2);
        check("t5_resumed", {15'd0, bus.running}, 16'd1);
        check("t5_resume_cnt", bus.utimer_bcd, 16'h0002);
        cyc(4);
        check("t5_step_0003", bus.utimer_bcd, 16'h0003);
        press(1);
        cyc(2);
        check("t5_clear", bus.utimer_bcd, 16'h0000);

        // 6: simultaneous start+clear, then reset mid-run
        bus.buttons_in = 2'b11;
        @(negedge clk);
        bus.buttons_in = 2'b00;
        cyc(2);
        check("t6_both_idle", {15'd0, bus.running}, 16'd0);
        cyc(8);
        check("t6_both_count", bus.utimer_bcd, 16'h0000);
        press(0);
        wait_count(16'h0037, 300, "t6_reach_0037");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_count", bus.utimer_bcd, 16'h0000);
        check("t6_rst_running", {15'd0, bus.running}, 16'd0);
        check("t6_rst_alarm", {15'd0, bus.alarm}, 16'd0);
        cyc(8);
        check("t6_rst_stays_idle", bus.utimer_bcd, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
